// File: rtl/cpu_jtag_ocimem_master.sv
// Debug memory-access sequencer: turns JTAG ocimem strobes into single-word Avalon-MM
// reads/writes with address auto-increment, and reports data/status back to the tck stage.
module cpu_jtag_ocimem_master #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  output logic        cmd_dropped
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         mon_q, mon_d;
  logic [31:0]         wd_q, wd_d;
  logic                err_q, err_d;
  logic                drop_q, drop_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                any_strobe;
  logic                unused_jdo;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mon_d   = mon_q;
    wd_d    = wd_q;
    err_d   = err_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_W+1:2];
          drop_d = 1'b0;
          if (jdo[35]) begin
            state_d = READ;
            err_d   = 1'b0;
            cnt_d   = '0;
          end
        end else if (take_action_ocimem_b) begin
          wd_d    = jdo[34:3];
          mon_d   = jdo[34:3];
          state_d = WRITE;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (take_no_action_ocimem_a) begin
          state_d = READ;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      READ, WRITE: begin
        if (any_strobe) drop_d = 1'b1;
        if (!avm_waitrequest) begin
          if (state_q == READ) mon_d = avm_readdata;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          // Slave stalled for TIMEOUT cycles: abandon without touching address or data.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write data is pure datapath and only observed while a write is in flight.
  always_ff @(posedge clk) begin
    wd_q <= wd_d;
  end

  assign avm_address    = BASE_ADDR + 32'({addr_q, 2'b00});
  assign avm_read       = (state_q == READ);
  assign avm_write      = (state_q == WRITE);
  assign avm_writedata  = wd_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mon_q;
  assign monitor_ready  = (state_q == IDLE);
  assign monitor_error  = err_q;
  assign cmd_dropped    = drop_q;

endmodule

// File: tb/tb_cpu_jtag_ocimem_master.sv
// Directed + randomized bench for cpu_jtag_ocimem_master against a transaction-level model.
module tb_cpu_jtag_ocimem_master;
  localparam int          ADDR_W  = 10;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          TIMEOUT = 255;
  localparam int unsigned AMOD    = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta, tb, tn;
  logic [31:0] avm_address, avm_writedata, avm_readdata, MonDReg;
  logic        avm_read, avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic        monitor_ready, monitor_error, cmd_dropped;

  cpu_jtag_ocimem_master #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta), .take_action_ocimem_b(tb), .take_no_action_ocimem_a(tn),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .cmd_dropped(cmd_dropped)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Transaction-level model of the debug-visible state.
  int unsigned m_addr;
  logic [31:0] m_mon;
  logic        m_err, m_drop;

  function automatic logic [31:0] exp_addr();
    return BASE + 32'(m_addr * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_jdo();
    jdo = {6'($urandom), $urandom};
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ready"},   32'(monitor_ready), 32'd1);
    chk({tag, ".read"},    32'(avm_read),      32'd0);
    chk({tag, ".write"},   32'(avm_write),     32'd0);
    chk({tag, ".addr"},    avm_address,        exp_addr());
    chk({tag, ".mon"},     MonDReg,            m_mon);
    chk({tag, ".err"},     32'(monitor_error), 32'(m_err));
    chk({tag, ".dropped"}, 32'(cmd_dropped),   32'(m_drop));
  endtask

  // Called in the first cycle after the strobe; plays the slave for `waits` stall cycles.
  task automatic run_bus(input string tag, input bit is_wr, input logic [31:0] data,
                         input int waits, input bit inject);
    int high = 0;
    bit completes = (waits < TIMEOUT);
    int exp_high = completes ? waits + 1 : TIMEOUT;
    chk({tag, ".busy_ready"}, 32'(monitor_ready), 32'd0);
    chk({tag, ".busy_err"},   32'(monitor_error), 32'd0);
    while ((is_wr ? avm_write : avm_read) && high < TIMEOUT + 5) begin
      chk({tag, ".req_addr"}, avm_address, exp_addr());
      chk({tag, ".other_req"}, 32'(is_wr ? avm_read : avm_write), 32'd0);
      if (is_wr) chk({tag, ".wdata"}, avm_writedata, data);
      if (high == 0) chk({tag, ".be"}, 32'(avm_byteenable), 32'hF);
      avm_waitrequest = (high < waits);
      avm_readdata    = (high < waits) ? $urandom : data;
      if (inject && high == 0) begin
        rand_jdo();
        case ($urandom_range(0, 2))
          0: ta = 1'b1;
          1: tb = 1'b1;
          default: tn = 1'b1;
        endcase
      end
      step();
      ta = 1'b0; tb = 1'b0; tn = 1'b0;
      high++;
    end
    avm_waitrequest = 1'b0;
    chk({tag, ".req_cycles"}, 32'(high), 32'(exp_high));
    if (completes) begin
      if (!is_wr) m_mon = data;
      m_addr = (m_addr + 1) % AMOD;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    if (inject) m_drop = 1'b1;
    check_idle(tag);
  endtask

  task automatic do_load(input string tag, input int unsigned addr, input bit rd,
                         input logic [31:0] data, input int waits, input bit all3);
    rand_jdo();
    jdo[ADDR_W+1:2] = ADDR_W'(addr);
    jdo[35] = rd;
    ta = 1'b1;
    if (all3) begin tb = 1'b1; tn = 1'b1; end
    step();
    ta = 1'b0; tb = 1'b0; tn = 1'b0;
    m_addr = addr % AMOD;
    m_drop = 1'b0;
    if (rd) run_bus(tag, 1'b0, data, waits, 1'b0);
    else    check_idle(tag);
  endtask

  task automatic do_write(input string tag, input logic [31:0] data, input int waits,
                          input bit with_n, input bit inject);
    rand_jdo();
    jdo[34:3] = data;
    tb = 1'b1;
    tn = with_n;
    step();
    tb = 1'b0; tn = 1'b0;
    m_mon = data;
    run_bus(tag, 1'b1, data, waits, inject);
  endtask

  task automatic do_read(input string tag, input logic [31:0] data, input int waits,
                         input bit inject);
    rand_jdo();
    tn = 1'b1;
    step();
    tn = 1'b0;
    run_bus(tag, 1'b0, data, waits, inject);
  endtask

  initial begin
    reset_n = 1'b0; jdo = '0; ta = 1'b0; tb = 1'b0; tn = 1'b0;
    avm_readdata = '0; avm_waitrequest = 1'b0;
    m_addr = 0; m_mon = '0; m_err = 1'b0; m_drop = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check_idle("reset");

    do_load("load10", 32'h10, 1'b0, '0, 0, 1'b0);
    chk("load10.byte_addr", avm_address, 32'h40);

    do_write("write", 32'hCAFEF00D, 0, 1'b0, 1'b0);
    chk("write.next_addr", avm_address, 32'h44);

    do_read("read1", 32'd1, 2, 1'b0);
    do_read("read2", 32'd2, 2, 1'b0);
    do_read("read3", 32'd3, 2, 1'b0);
    chk("reads.next_addr", avm_address, 32'h50);

    do_read("timeout", $urandom, 400, 1'b0);
    do_write("timeout_w", $urandom, TIMEOUT, 1'b0, 1'b0);
    do_read("edge_ok", $urandom, TIMEOUT - 1, 1'b0);

    do_load("wrap", 32'h3FF, 1'b1, 32'h1234_5678, 1, 1'b0);
    chk("wrap.addr0", avm_address, BASE);

    do_read("drop_rd", 32'hA5A5_0001, 3, 1'b1);
    do_write("drop_wr", 32'h0BAD_BEEF, 0, 1'b0, 1'b1);
    do_load("clear_drop", 32'h2A, 1'b0, '0, 0, 1'b0);

    do_load("prio_a", 32'h55, 1'b0, '0, 0, 1'b1);
    do_write("prio_b", 32'h600D_CAFE, 1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 3);
      int w    = $urandom_range(0, 4);
      bit inj  = ($urandom_range(0, 5) == 0);
      case (kind)
        0: do_read("rnd_rd", $urandom, w, inj);
        1: do_write("rnd_wr", $urandom, w, 1'b0, inj);
        2: do_load("rnd_ld", $urandom_range(0, AMOD - 1), 1'b1, $urandom, w, 1'b0);
        default: do_load("rnd_la", $urandom_range(0, AMOD - 1), 1'b0, '0, 0, 1'b0);
      endcase
    end

    // Reset while a read is stalled.
    rand_jdo();
    tn = 1'b1;
    step();
    tn = 1'b0;
    avm_waitrequest = 1'b1;
    chk("rst_mid.req", 32'(avm_read), 32'd1);
    step(); step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    m_addr = 0; m_mon = '0; m_err = 1'b0; m_drop = 1'b0;
    check_idle("rst_mid");
    step();
    check_idle("rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
